// File: rtl/bsr_block_scheduler.sv
// Walks BSR row_ptr/col_idx metadata for one weight matrix and issues weight-buffer then
// activation-buffer reads for every non-zero block, with array strobes delayed by the 1-cycle buffer latency.
module bsr_block_scheduler #(
    parameter int N_ROWS  = 16,
    parameter int N_COLS  = 16,
    parameter int META_AW = 16,
    parameter int IDX_W   = 16,
    parameter int K_W     = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [IDX_W-1:0]                 num_blk_rows,
    input  logic [K_W-1:0]                   k_len,
    output logic                             busy,
    output logic                             done,
    output logic                             meta_req,
    output logic                             meta_sel,
    output logic [META_AW-1:0]               meta_addr,
    input  logic                             meta_rvalid,
    input  logic [IDX_W-1:0]                 meta_rdata,
    output logic                             wgt_rd_en,
    output logic [IDX_W+$clog2(N_ROWS)-1:0]  wgt_rd_addr,
    output logic                             act_rd_en,
    output logic [IDX_W-1:0]                 act_blk,
    output logic [K_W-1:0]                   act_k,
    output logic                             load_weight,
    output logic                             block_valid,
    output logic                             row_done,
    output logic [IDX_W-1:0]                 row_idx
);

    localparam int ROW_W = $clog2(N_ROWS);

    if (N_ROWS < 2 || N_COLS < 1) begin : g_param_check
        $error("bsr_block_scheduler: N_ROWS must be >= 2 and N_COLS >= 1");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_PTR_LO, S_PTR_HI, S_COL, S_LOAD_W, S_STREAM, S_DRAIN, S_ROW_END, S_FIN
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     nbr_q, nbr_d;
    logic [K_W-1:0]       klen_q, klen_d;
    logic [IDX_W-1:0]     r_q, r_d;
    logic [IDX_W-1:0]     j_q, j_d;
    logic [IDX_W-1:0]     end_q, end_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [K_W-1:0]       act_k_q, act_k_d;
    logic [IDX_W-1:0]     act_blk_q, act_blk_d;
    logic                 meta_req_q, meta_req_d;
    logic                 meta_sel_q, meta_sel_d;
    logic [META_AW-1:0]   meta_addr_q, meta_addr_d;
    logic                 wgt_rd_en_q, wgt_rd_en_d;
    logic                 act_rd_en_q, act_rd_en_d;
    logic                 load_weight_q, load_weight_d;
    logic                 block_valid_q, block_valid_d;
    logic                 row_done_q, row_done_d;
    logic [IDX_W-1:0]     row_idx_q, row_idx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [IDX_W:0]       r_inc, j_inc;
    logic                 meta_ack;

    // Metadata handshake: meta_req is a 1-cycle pulse, at most one request is outstanding,
    // and the single response is taken on meta_rvalid only in a wait state after the pulse.
    assign meta_ack = meta_rvalid && !meta_req_q;
    assign r_inc    = {1'b0, r_q} + {{IDX_W{1'b0}}, 1'b1};
    assign j_inc    = {1'b0, j_q} + {{IDX_W{1'b0}}, 1'b1};

    always_comb begin
        state_d       = state_q;
        nbr_d         = nbr_q;
        klen_d        = klen_q;
        r_d           = r_q;
        j_d           = j_q;
        end_d         = end_q;
        row_d         = row_q;
        act_k_d       = act_k_q;
        act_blk_d     = act_blk_q;
        meta_req_d    = 1'b0;
        meta_sel_d    = meta_sel_q;
        meta_addr_d   = meta_addr_q;
        wgt_rd_en_d   = 1'b0;
        act_rd_en_d   = 1'b0;
        load_weight_d = wgt_rd_en_q;
        block_valid_d = act_rd_en_q;
        row_done_d    = 1'b0;
        row_idx_d     = row_idx_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A start landing on the done cycle belongs to the previous run and is dropped.
                if (start && !done_q) begin
                    nbr_d  = num_blk_rows;
                    klen_d = (k_len == '0) ? K_W'(1) : k_len;
                    r_d    = '0;
                    busy_d = 1'b1;
                    if (num_blk_rows == '0) begin
                        state_d = S_FIN;
                    end else begin
                        state_d     = S_PTR_LO;
                        meta_req_d  = 1'b1;
                        meta_sel_d  = 1'b0;
                        meta_addr_d = '0;
                    end
                end
            end
            S_PTR_LO: begin
                if (meta_ack) begin
                    j_d         = meta_rdata;
                    state_d     = S_PTR_HI;
                    meta_req_d  = 1'b1;
                    meta_sel_d  = 1'b0;
                    meta_addr_d = META_AW'(r_inc);
                end
            end
            S_PTR_HI: begin
                if (meta_ack) begin
                    end_d = meta_rdata;
                    if (meta_rdata <= j_q) begin
                        state_d    = S_ROW_END;
                        row_done_d = 1'b1;
                        row_idx_d  = r_q;
                    end else begin
                        state_d     = S_COL;
                        meta_req_d  = 1'b1;
                        meta_sel_d  = 1'b1;
                        meta_addr_d = META_AW'(j_q);
                    end
                end
            end
            S_COL: begin
                if (meta_ack) begin
                    act_blk_d   = meta_rdata;
                    state_d     = S_LOAD_W;
                    wgt_rd_en_d = 1'b1;
                    row_d       = '0;
                end
            end
            S_LOAD_W: begin
                if (row_q == ROW_W'(N_ROWS - 1)) begin
                    state_d     = S_STREAM;
                    act_rd_en_d = 1'b1;
                    act_k_d     = '0;
                end else begin
                    wgt_rd_en_d = 1'b1;
                    row_d       = row_q + ROW_W'(1);
                end
            end
            S_STREAM: begin
                if (act_k_q == klen_q - K_W'(1)) begin
                    state_d = S_DRAIN;
                end else begin
                    act_rd_en_d = 1'b1;
                    act_k_d     = act_k_q + K_W'(1);
                end
            end
            S_DRAIN: begin
                j_d = j_inc[IDX_W-1:0];
                if (j_inc < {1'b0, end_q}) begin
                    state_d     = S_COL;
                    meta_req_d  = 1'b1;
                    meta_sel_d  = 1'b1;
                    meta_addr_d = META_AW'(j_inc);
                end else begin
                    state_d    = S_ROW_END;
                    row_done_d = 1'b1;
                    row_idx_d  = r_q;
                end
            end
            S_ROW_END: begin
                r_d = r_inc[IDX_W-1:0];
                if (r_inc < {1'b0, nbr_q}) begin
                    state_d     = S_PTR_LO;
                    meta_req_d  = 1'b1;
                    meta_sel_d  = 1'b0;
                    meta_addr_d = META_AW'(r_inc);
                end else begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            nbr_q         <= '0;
            klen_q        <= '0;
            r_q           <= '0;
            j_q           <= '0;
            end_q         <= '0;
            row_q         <= '0;
            act_k_q       <= '0;
            act_blk_q     <= '0;
            meta_req_q    <= 1'b0;
            meta_sel_q    <= 1'b0;
            meta_addr_q   <= '0;
            wgt_rd_en_q   <= 1'b0;
            act_rd_en_q   <= 1'b0;
            load_weight_q <= 1'b0;
            block_valid_q <= 1'b0;
            row_done_q    <= 1'b0;
            row_idx_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            nbr_q         <= nbr_d;
            klen_q        <= klen_d;
            r_q           <= r_d;
            j_q           <= j_d;
            end_q         <= end_d;
            row_q         <= row_d;
            act_k_q       <= act_k_d;
            act_blk_q     <= act_blk_d;
            meta_req_q    <= meta_req_d;
            meta_sel_q    <= meta_sel_d;
            meta_addr_q   <= meta_addr_d;
            wgt_rd_en_q   <= wgt_rd_en_d;
            act_rd_en_q   <= act_rd_en_d;
            load_weight_q <= load_weight_d;
            block_valid_q <= block_valid_d;
            row_done_q    <= row_done_d;
            row_idx_q     <= row_idx_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign meta_req    = meta_req_q;
    assign meta_sel    = meta_sel_q;
    assign meta_addr   = meta_addr_q;
    assign wgt_rd_en   = wgt_rd_en_q;
    assign wgt_rd_addr = {j_q, row_q};
    assign act_rd_en   = act_rd_en_q;
    assign act_blk     = act_blk_q;
    assign act_k       = act_k_q;
    assign load_weight = load_weight_q;
    assign block_valid = block_valid_q;
    assign row_done    = row_done_q;
    assign row_idx     = row_idx_q;

endmodule

// File: tb/tb_bsr_block_scheduler.sv
// Bench for bsr_block_scheduler: metadata memory with random read latency, and a scoreboard fed
// by a block-level model of the BSR walk (per row, per block: weight rows, then activation vectors).
module tb_bsr_block_scheduler;

    localparam int N_ROWS  = 16;
    localparam int N_COLS  = 16;
    localparam int META_AW = 16;
    localparam int IDX_W   = 16;
    localparam int K_W     = 16;
    localparam int AW      = IDX_W + $clog2(N_ROWS);

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [IDX_W-1:0]   num_blk_rows;
    logic [K_W-1:0]     k_len;
    logic               busy, done, meta_req, meta_sel;
    logic [META_AW-1:0] meta_addr;
    logic               meta_rvalid;
    logic [IDX_W-1:0]   meta_rdata;
    logic               wgt_rd_en;
    logic [AW-1:0]      wgt_rd_addr;
    logic               act_rd_en;
    logic [IDX_W-1:0]   act_blk;
    logic [K_W-1:0]     act_k;
    logic               load_weight, block_valid, row_done;
    logic [IDX_W-1:0]   row_idx;

    bsr_block_scheduler #(
        .N_ROWS(N_ROWS), .N_COLS(N_COLS), .META_AW(META_AW), .IDX_W(IDX_W), .K_W(K_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_blk_rows(num_blk_rows), .k_len(k_len),
        .busy(busy), .done(done), .meta_req(meta_req), .meta_sel(meta_sel), .meta_addr(meta_addr),
        .meta_rvalid(meta_rvalid), .meta_rdata(meta_rdata), .wgt_rd_en(wgt_rd_en),
        .wgt_rd_addr(wgt_rd_addr), .act_rd_en(act_rd_en), .act_blk(act_blk), .act_k(act_k),
        .load_weight(load_weight), .block_valid(block_valid), .row_done(row_done), .row_idx(row_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [IDX_W-1:0] row_ptr_mem [0:63];
    logic [IDX_W-1:0] col_mem     [0:255];
    int lat_max;

    logic [AW-1:0]        exp_wgt[$];
    logic [IDX_W+K_W-1:0] exp_act[$];
    logic [IDX_W-1:0]     exp_row[$];
    int exp_blocks, exp_bv_total;
    int n_lw, n_bv, n_done, n_busy, n_meta_req;

    // Metadata memory: one response per request after 1..lat_max cycles.
    initial begin : meta_responder
        bit               pend;
        bit               pend_sel;
        logic [META_AW-1:0] pend_addr;
        int               lat_cnt;
        pend = 0; pend_sel = 0; pend_addr = '0; lat_cnt = 0;
        meta_rvalid = 1'b0;
        meta_rdata  = '0;
        forever begin
            @(posedge clk); #1;
            meta_rvalid = 1'b0;
            if (!rst_n) begin
                pend = 0;
            end else begin
                if (pend) begin
                    lat_cnt--;
                    if (lat_cnt == 0) begin
                        meta_rvalid = 1'b1;
                        meta_rdata  = pend_sel ? col_mem[pend_addr] : row_ptr_mem[pend_addr];
                        pend = 0;
                    end
                end
                if (meta_req) begin
                    n_meta_req++;
                    checks++;
                    if (pend) begin
                        errors++;
                        $display("FAIL meta_outstanding: got second request addr %0d while one pending, required none", meta_addr);
                    end
                    pend      = 1;
                    pend_sel  = meta_sel;
                    pend_addr = meta_addr;
                    lat_cnt   = $urandom_range(lat_max, 1);
                end
            end
        end
    end

    // Scoreboard monitor: address streams in order, strobe alignment, counters.
    initial begin : monitor
        logic prev_wgt, prev_act;
        prev_wgt = 1'b0; prev_act = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                prev_wgt = 1'b0; prev_act = 1'b0;
            end else begin
                checks++;
                if (load_weight !== prev_wgt) begin
                    errors++;
                    $display("FAIL load_weight_align: got %b required %b", load_weight, prev_wgt);
                end
                checks++;
                if (block_valid !== prev_act) begin
                    errors++;
                    $display("FAIL block_valid_align: got %b required %b", block_valid, prev_act);
                end
                if (load_weight && block_valid) begin
                    errors++;
                    $display("FAIL strobe_overlap: got load_weight=1 block_valid=1 required not both");
                end
                if (wgt_rd_en) begin
                    checks++;
                    if (exp_wgt.size() == 0) begin
                        errors++;
                        $display("FAIL wgt_extra: got read addr %h required no read", wgt_rd_addr);
                    end else if (wgt_rd_addr !== exp_wgt[0]) begin
                        errors++;
                        $display("FAIL wgt_addr: got %h required %h", wgt_rd_addr, exp_wgt.pop_front());
                    end else begin
                        void'(exp_wgt.pop_front());
                    end
                end
                if (act_rd_en) begin
                    checks++;
                    if (exp_act.size() == 0) begin
                        errors++;
                        $display("FAIL act_extra: got blk %0d k %0d required no read", act_blk, act_k);
                    end else if ({act_blk, act_k} !== exp_act[0]) begin
                        errors++;
                        $display("FAIL act_addr: got {blk,k} %h required %h", {act_blk, act_k}, exp_act.pop_front());
                    end else begin
                        void'(exp_act.pop_front());
                    end
                end
                if (row_done) begin
                    checks++;
                    if (exp_row.size() == 0) begin
                        errors++;
                        $display("FAIL row_done_extra: got row_idx %0d required no row_done", row_idx);
                    end else if (row_idx !== exp_row[0]) begin
                        errors++;
                        $display("FAIL row_idx: got %0d required %0d", row_idx, exp_row.pop_front());
                    end else begin
                        void'(exp_row.pop_front());
                    end
                end
                if (load_weight) n_lw++;
                if (block_valid) n_bv++;
                if (done)        n_done++;
                if (busy)        n_busy++;
                prev_wgt = wgt_rd_en;
                prev_act = act_rd_en;
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic clear_sb();
        exp_wgt.delete(); exp_act.delete(); exp_row.delete();
        n_lw = 0; n_bv = 0; n_done = 0; n_busy = 0; n_meta_req = 0;
        exp_blocks = 0; exp_bv_total = 0;
    endtask

    // Reference: every block j in [row_ptr[r], row_ptr[r+1]) loads N_ROWS weight rows, then k' vectors.
    task automatic build_model(input int rows, input int kl);
        int kk, lo, hi;
        kk = (kl == 0) ? 1 : kl;
        for (int r = 0; r < rows; r++) begin
            lo = int'(row_ptr_mem[r]);
            hi = int'(row_ptr_mem[r+1]);
            for (int j = lo; j < hi; j++) begin
                for (int i = 0; i < N_ROWS; i++) exp_wgt.push_back(AW'(j * N_ROWS + i));
                for (int k = 0; k < kk; k++) exp_act.push_back({col_mem[j], K_W'(k)});
                exp_blocks++;
                exp_bv_total += kk;
            end
            exp_row.push_back(IDX_W'(r));
        end
    endtask

    task automatic pulse_start(input int rows, input int kl);
        num_blk_rows = IDX_W'(rows);
        k_len        = K_W'(kl);
        start        = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(posedge clk); #2;
            if (done) ok = 1;
        end
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({busy, done, meta_req, meta_sel, meta_addr, wgt_rd_en, wgt_rd_addr, act_rd_en, act_blk,
             act_k, load_weight, block_valid, row_done, row_idx} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b meta_req=%b wgt_rd_en=%b act_rd_en=%b required all zero",
                     busy, done, meta_req, wgt_rd_en, act_rd_en);
        end
        rst_n = 1'b1;
        settle();
        checks++;
        if ({busy, done, meta_req, wgt_rd_en, act_rd_en, row_done} !== '0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b done=%b meta_req=%b required zero", busy, done, meta_req);
        end
    endtask

    task automatic test_single_block();
        bit ok;
        row_ptr_mem[0] = 0; row_ptr_mem[1] = 1; col_mem[0] = 3; lat_max = 1;
        clear_sb(); build_model(1, 4);
        pulse_start(1, 4);
        wait_done(2000, ok);
        settle();
        checks++;
        if (!ok) begin errors++; $display("FAIL single_timeout: got no done required done"); end
        checks++;
        if (n_lw != 16 || n_bv != 4) begin
            errors++;
            $display("FAIL single_counts: got load_weight=%0d block_valid=%0d required 16 and 4", n_lw, n_bv);
        end
        checks++;
        if (n_done != 1 || exp_wgt.size() != 0 || exp_act.size() != 0 || exp_row.size() != 0) begin
            errors++;
            $display("FAIL single_drain: got done=%0d left wgt=%0d act=%0d row=%0d required 1,0,0,0",
                     n_done, exp_wgt.size(), exp_act.size(), exp_row.size());
        end
    endtask

    task automatic test_empty_rows();
        bit ok;
        row_ptr_mem[0] = 0; row_ptr_mem[1] = 0; row_ptr_mem[2] = 2; row_ptr_mem[3] = 2;
        col_mem[0] = 5; col_mem[1] = 9; lat_max = 2;
        clear_sb(); build_model(3, 2);
        pulse_start(3, 2);
        wait_done(2000, ok);
        settle();
        checks++;
        if (!ok) begin errors++; $display("FAIL empty_timeout: got no done required done"); end
        checks++;
        if (n_lw != 2 * N_ROWS || n_bv != 4 || n_done != 1) begin
            errors++;
            $display("FAIL empty_counts: got lw=%0d bv=%0d done=%0d required %0d 4 1", n_lw, n_bv, n_done, 2 * N_ROWS);
        end
        checks++;
        if (exp_wgt.size() != 0 || exp_act.size() != 0 || exp_row.size() != 0) begin
            errors++;
            $display("FAIL empty_drain: got left wgt=%0d act=%0d row=%0d required 0",
                     exp_wgt.size(), exp_act.size(), exp_row.size());
        end
    endtask

    task automatic test_zero_rows();
        bit ok;
        clear_sb();
        pulse_start(0, 3);
        wait_done(10, ok);
        settle();
        checks++;
        if (!ok) begin errors++; $display("FAIL zero_rows_timeout: got no done required done"); end
        checks++;
        if (n_meta_req != 0 || n_busy > 2 || n_done != 1) begin
            errors++;
            $display("FAIL zero_rows: got meta_req=%0d busy_cycles=%0d done=%0d required 0, <=2, 1",
                     n_meta_req, n_busy, n_done);
        end
    endtask

    task automatic test_zero_klen();
        bit ok;
        row_ptr_mem[0] = 0; row_ptr_mem[1] = 2; col_mem[0] = 7; col_mem[1] = 8; lat_max = 3;
        clear_sb(); build_model(1, 0);
        pulse_start(1, 0);
        wait_done(2000, ok);
        settle();
        checks++;
        if (!ok) begin errors++; $display("FAIL klen0_timeout: got no done required done"); end
        checks++;
        if (n_bv != 2 || exp_act.size() != 0 || n_lw != 2 * N_ROWS) begin
            errors++;
            $display("FAIL klen0_counts: got bv=%0d lw=%0d act_left=%0d required 2 %0d 0", n_bv, n_lw, exp_act.size(), 2 * N_ROWS);
        end
    endtask

    task automatic test_random_latency();
        bit ok;
        int rows, kl, v;
        for (int it = 0; it < 4; it++) begin
            rows = $urandom_range(6, 1);
            kl   = $urandom_range(5, 0);
            row_ptr_mem[0] = IDX_W'($urandom_range(3, 0));
            for (int r = 1; r <= rows; r++) begin
                v = int'(row_ptr_mem[r-1]);
                if ($urandom_range(5, 0) == 0 && v > 0) v = v - 1;
                else v = v + $urandom_range(3, 0);
                row_ptr_mem[r] = IDX_W'(v);
            end
            for (int c = 0; c < 64; c++) col_mem[c] = IDX_W'($urandom_range(1000, 0));
            for (int pass = 0; pass < 2; pass++) begin
                lat_max = (pass == 0) ? 1 : 7;
                clear_sb(); build_model(rows, kl);
                pulse_start(rows, kl);
                @(posedge clk); #2;
                pulse_start(rows + 3, kl + 2);
                wait_done(5000, ok);
                settle();
                checks++;
                if (!ok) begin errors++; $display("FAIL rand_timeout: iter %0d pass %0d got no done", it, pass); end
                checks++;
                if (n_done != 1 || n_lw != exp_blocks * N_ROWS || n_bv != exp_bv_total) begin
                    errors++;
                    $display("FAIL rand_counts: iter %0d got done=%0d lw=%0d bv=%0d required 1 %0d %0d",
                             it, n_done, n_lw, n_bv, exp_blocks * N_ROWS, exp_bv_total);
                end
                checks++;
                if (exp_wgt.size() != 0 || exp_act.size() != 0 || exp_row.size() != 0) begin
                    errors++;
                    $display("FAIL rand_drain: iter %0d got left wgt=%0d act=%0d row=%0d required 0",
                             it, exp_wgt.size(), exp_act.size(), exp_row.size());
                end
            end
        end
    endtask

    task automatic test_start_on_done();
        bit ok;
        row_ptr_mem[0] = 0; row_ptr_mem[1] = 1; col_mem[0] = 11; lat_max = 1;
        clear_sb(); build_model(1, 1);
        pulse_start(1, 1);
        wait_done(2000, ok);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        checks++;
        if (!ok || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_on_done: got done_seen=%b busy=%b required 1 and 0", ok, busy);
        end
        settle();
        checks++;
        if (n_meta_req != 3 || n_done != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_on_done_traffic: got meta_req=%0d done=%0d busy=%b required 3 1 0", n_meta_req, n_done, busy);
        end
    endtask

    task automatic test_reset_mid_load();
        bit ok;
        row_ptr_mem[0] = 0; row_ptr_mem[1] = 1; col_mem[0] = 4; lat_max = 1;
        clear_sb(); build_model(1, 3);
        pulse_start(1, 3);
        ok = 0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(posedge clk); #2;
            if (wgt_rd_en) ok = 1;
        end
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (!ok || {busy, done, meta_req, wgt_rd_en, wgt_rd_addr, act_rd_en, load_weight, block_valid,
                    row_done, act_blk} !== '0) begin
            errors++;
            $display("FAIL reset_mid_load: got reached_load=%b busy=%b wgt_rd_en=%b load_weight=%b required 1 then zeros",
                     ok, busy, wgt_rd_en, load_weight);
        end
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (n_done != 0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d done pulses required 0", n_done);
        end
        rst_n = 1'b1;
        @(posedge clk); #2;
        clear_sb(); build_model(1, 3);
        pulse_start(1, 3);
        wait_done(2000, ok);
        settle();
        checks++;
        if (!ok || n_done != 1 || n_lw != N_ROWS || n_bv != 3 || exp_wgt.size() != 0 || exp_act.size() != 0) begin
            errors++;
            $display("FAIL reset_rerun: got done=%0d lw=%0d bv=%0d required 1 %0d 3", n_done, n_lw, n_bv, N_ROWS);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; num_blk_rows = '0; k_len = '0; lat_max = 1;
        for (int i = 0; i < 64; i++)  row_ptr_mem[i] = '0;
        for (int i = 0; i < 256; i++) col_mem[i] = '0;
        clear_sb();
        test_reset();
        test_single_block();
        test_empty_rows();
        test_zero_rows();
        test_zero_klen();
        test_random_latency();
        test_start_on_done();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
